// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants, state type and helpers for the BCD-to-binary converter
// Purpose: digit width and limit, converter FSM states, and the constant functions
//          used to size the digit counter and to check the output width.
// Ports:   none (package).
package bcd_pkg;

  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - combinational acc*10 + digit step for the BCD-to-binary converter
// Purpose: one multiply-add step of the Horner evaluation, modulo 2**BIN_W, plus an
//          illegal-digit flag.
// Ports:
//   acc_i        in   BIN_W  running accumulator
//   digit_i      in   4      digit being consumed (raw 0..15)
//   acc_o        out  BIN_W  (acc_i*10 + digit_i) mod 2**BIN_W
//   digit_bad_o  out  1      digit_i > 9
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 10
) (
  input  logic [BIN_W-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]   acc_o,
  output logic               digit_bad_o
);

  // x*10 as x*8 + x*2 keeps this a pair of shifts and adders.
  assign acc_o       = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
  assign digit_bad_o = (digit_i > MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to unsigned binary converter, one digit per clock
// Purpose: accepts an NDIG-digit packed BCD word, evaluates acc = acc*10 + digit MSD first,
//          and presents the binary result on a valid/ready output.
// Optional feature macro: BCD2BIN_CHECK_EN (illegal-digit detection; result forced to 0, err=1).
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        bcd_in valid
//   in_ready   out  1        high only in IDLE
//   bcd_in     in   4*NDIG   packed BCD, top nibble = most significant digit
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        consumer takes result
//   bin_out    out  BIN_W    binary result, holds last value between results
//   err        out  1        illegal-digit flag (0 when BCD2BIN_CHECK_EN is undefined)
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*NDIG-1:0] bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int               WORD_W   = DIGIT_W * NDIG;
  localparam int               CNT_W    = clog2(NDIG + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG);

  if ((longint'(1) << BIN_W) <= pow10(NDIG) - 1) begin : g_bin_w_too_small
    $error("bcd_to_bin_seq: BIN_W too small to hold 10**NDIG - 1");
  end

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [BIN_W-1:0]   mac_acc;
  logic [DIGIT_W-1:0] msd;

`ifdef BCD2BIN_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
  logic digit_bad;
`endif

  assign msd = shreg_q[WORD_W-1 -: DIGIT_W];

  bcd_digit_mac #(
    .BIN_W       (BIN_W)
  ) u_mac (
    .acc_i       (acc_q),
    .digit_i     (msd),
`ifdef BCD2BIN_CHECK_EN
    .digit_bad_o (digit_bad),
`else
    .digit_bad_o (),
`endif
    .acc_o       (mac_acc)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
`ifdef BCD2BIN_CHECK_EN
    bad_d       = bad_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
`ifdef BCD2BIN_CHECK_EN
          bad_d   = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      CONV: begin
        // NDIG multiply-add cycles, then one more cycle that publishes the
        // accumulator into the output registers together with out_valid.
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
`ifdef BCD2BIN_CHECK_EN
          bin_d       = bad_q ? '0 : acc_q;
          err_d       = bad_q;
`else
          bin_d       = acc_q;
`endif
        end else begin
          acc_d   = mac_acc;
          shreg_d = shreg_q << DIGIT_W;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef BCD2BIN_CHECK_EN
          bad_d   = bad_q | digit_bad;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
`ifdef BCD2BIN_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
`ifdef BCD2BIN_CHECK_EN
      bad_q       <= bad_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
`ifdef BCD2BIN_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq
`timescale 1ns/1ps
module tb_bcd_to_bin_seq;

  localparam int NDIG   = 3;
  localparam int BIN_W  = 10;
  localparam int WORD_W = 4 * NDIG;
  localparam int LAT    = NDIG + 1;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] bcd_in    = '0;
  logic              in_ready;
  logic              out_valid;
  logic              err;
  logic [BIN_W-1:0]  bin_out;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;

  int exp_val_q[$];
  int exp_err_q[$];
  bit busy     = 1'b0;
  int acc_cyc  = 0;
  int cyc      = 0;
  int last_val = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(
    .NDIG      (NDIG),
    .BIN_W     (BIN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal value of the digits, each weighted by its raw nibble value.
  function automatic void model(input logic [WORD_W-1:0] w, output int v, output int e);
    int d;
    v = 0;
    e = 0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      d = int'((w >> (4 * k)) & WORD_W'(15));
      if (d > 9) e = 1;
      v = (v * 10 + d) % (1 << BIN_W);
    end
`ifdef BCD2BIN_CHECK_EN
    if (e != 0) v = 0;
`else
    e = 0;
`endif
  endfunction

  function automatic logic [WORD_W-1:0] to_bcd(input int n);
    logic [WORD_W-1:0] w;
    int r;
    w = '0;
    r = n;
    for (int k = 0; k < NDIG; k++) begin
      w[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return w;
  endfunction

  // Per-cycle compare against the transaction-level model.
  always @(negedge clk) begin
    int v;
    int e;
    cyc++;
    if (!rst_n) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_bin_out", int'(bin_out), 0);
      chk("rst_err", int'(err), 0);
      busy = 1'b0;
      exp_val_q.delete();
      exp_err_q.delete();
      last_val = 0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!busy));
      chk("out_valid", int'(out_valid), int'(busy && (cyc >= acc_cyc + LAT + 1)));
      if (out_valid) begin
        if (exp_val_q.size() == 0) begin
          chk("out_unexpected", 1, 0);
        end else begin
          chk("bin_out", int'(bin_out), exp_val_q[0]);
          chk("err", int'(err), exp_err_q[0]);
          if (out_ready) begin
            last_val = exp_val_q.pop_front();
            void'(exp_err_q.pop_front());
            busy = 1'b0;
          end
        end
      end else begin
        chk("bin_hold", int'(bin_out), last_val);
      end
      if (in_valid && in_ready) begin
        model(bcd_in, v, e);
        exp_val_q.push_back(v);
        exp_err_q.push_back(e);
        busy = 1'b1;
        acc_cyc = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [WORD_W-1:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    bcd_in   = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in   = WORD_W'($urandom);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic get_result(output int v, output int e);
    bit ok;
    ok = 1'b0;
    v = -1;
    e = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        v  = int'(bin_out);
        e  = int'(err);
        ok = 1'b1;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v;
    int  e;
    int  n;
    bit  hit;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    model(12'h999, v, e);
    chk("model_999", v, 999);
    model(12'h407, v, e);
    chk("model_407", v, 407);
    model(12'h000, v, e);
    chk("model_000", v, 0);
    model(12'h1A3, v, e);
`ifdef BCD2BIN_CHECK_EN
    chk("model_1A3_val", v, 0);
    chk("model_1A3_err", e, 1);
`else
    chk("model_1A3_val", v, 203);
    chk("model_1A3_err", e, 0);
`endif

    // 999 with out_ready high: latency from accept edge.
    rdy_mode = 0;
    send(12'h999);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) hit = 1'b1;
    end
    chk("latency_999", n, 4);
    chk("bin_999", int'(bin_out), 999);
    chk("err_999", int'(err), 0);
    repeat (3) @(posedge clk);

    // 000 then 407 back-to-back, in_valid held through CONV/DONE.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    bcd_in   = 12'h000;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (in_ready) hit = 1'b1;
    end
    @(posedge clk);
    #1;
    bcd_in = 12'h407;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (in_ready) hit = 1'b1;
      else n++;
    end
    chk("gap_in_ready_low", n, 5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    get_result(v, e);
    chk("bin_407", v, 407);

    // 250 with a 10-cycle consumer stall.
    rdy_mode = 2;
    send(12'h250);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (out_valid) hit = 1'b1;
    end
    chk("stall_valid_seen", int'(hit), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      chk("stall_hold_valid", int'(out_valid), 1);
      chk("stall_hold_bin", int'(bin_out), 250);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("stall_release_valid", int'(out_valid), 0);
    chk("stall_release_bin", int'(bin_out), 250);

    // Reset in the 2nd CONV cycle aborts the word.
    send(12'h123);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      chk("abort_no_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 1);
    end
    send(12'h321);
    get_result(v, e);
    chk("bin_321", v, 321);

    // Illegal digit.
    send(12'h1A3);
    get_result(v, e);
`ifdef BCD2BIN_CHECK_EN
    chk("bin_1A3", v, 0);
    chk("err_1A3", e, 1);
`else
    chk("bin_1A3", v, 203);
    chk("err_1A3", e, 0);
`endif

    // Full legal sweep, then random raw words, with random consumer stalls.
    rdy_mode = 1;
    for (int d = 0; d < 1000; d++) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      send(to_bcd(d));
    end
    for (int i = 0; i < 200; i++) begin
      send(WORD_W'($urandom));
    end
    rdy_mode = 0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (!busy && exp_val_q.size() == 0) hit = 1'b1;
    end
    chk("drain", int'(hit), 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
